// File: rtl/touch_gesture_decoder.sv
// Touch gesture decoder: classifies debounced touch presses into
// single tap, double tap or long press events with a valid/ack handshake.
module touch_gesture_decoder #(
    parameter int CNT_W             = 16,
    parameter int MIN_PRESS_CYCLES  = 4,
    parameter int LONG_PRESS_CYCLES = 64,
    parameter int DOUBLE_GAP_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       event_ack,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       overrun,
    output logic       hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_PRESS2,
        S_LONG
    } state_t;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SINGLE = 2'b01;
    localparam logic [1:0] EV_DOUBLE = 2'b10;
    localparam logic [1:0] EV_LONG   = 2'b11;

    localparam logic [CNT_W:0] MIN_T  = MIN_PRESS_CYCLES[CNT_W:0];
    localparam logic [CNT_W:0] LONG_T = LONG_PRESS_CYCLES[CNT_W:0];
    localparam logic [CNT_W:0] GAP_T  = DOUBLE_GAP_CYCLES[CNT_W:0];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               btn_q;
    logic               ev_valid_q, ev_valid_d;
    logic [1:0]         ev_code_q, ev_code_d;
    logic               overrun_q, overrun_d;
    logic               hold_q, hold_d;

    logic               rise;
    logic               fall;
    logic               emit;
    logic [1:0]         emit_code;
    logic [CNT_W:0]     cnt_p1;
    logic [CNT_W:0]     cnt_p2;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    // cnt_q counts edges since state entry; the entry edge itself was
    // already one sample of the current level, so the sample taken now
    // is number cnt_q+2 and the samples before it number cnt_q+1.
    assign cnt_p1 = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_p2 = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, 2'b10};

    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_code = EV_NONE;
        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = (cnt_p1 < MIN_T) ? S_IDLE : S_GAP;
                end else if (cnt_p2 >= LONG_T) begin
                    state_d   = S_LONG;
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_PRESS2;
                end else if (cnt_p2 >= GAP_T) begin
                    state_d   = S_IDLE;
                    emit      = 1'b1;
                    emit_code = EV_SINGLE;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    emit      = 1'b1;
                    emit_code = (cnt_p1 >= MIN_T) ? EV_DOUBLE : EV_SINGLE;
                end else if (cnt_p2 >= LONG_T) begin
                    // the pending first tap is dropped in favour of the long press
                    state_d   = S_LONG;
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        overrun_d  = overrun_q;
        hold_d     = (state_d == S_LONG);

        if (emit) begin
            if (!ev_valid_q || event_ack) begin
                ev_valid_d = 1'b1;
                ev_code_d  = emit_code;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ev_valid_q && event_ack) begin
            ev_valid_d = 1'b0;
            ev_code_d  = EV_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            btn_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_NONE;
            overrun_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            overrun_q  <= overrun_d;
            hold_q     <= hold_d;
        end
    end

    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign overrun     = overrun_q;
    assign hold        = hold_q;

endmodule

// File: tb/tb_touch_gesture_decoder.sv
// Directed testbench for touch_gesture_decoder.
// Observed vector is {event_valid, event_code, overrun, hold}.
module tb_touch_gesture_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       event_ack;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overrun;
    logic       hold;
    logic [4:0] obs;

    int total = 0;
    int bad   = 0;

    assign obs = {event_valid, event_code, overrun, hold};

    always #5 clk = ~clk;

    touch_gesture_decoder #(
        .CNT_W(16),
        .MIN_PRESS_CYCLES(4),
        .LONG_PRESS_CYCLES(64),
        .DOUBLE_GAP_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .event_ack(event_ack),
        .event_valid(event_valid),
        .event_code(event_code),
        .overrun(overrun),
        .hold(hold)
    );

    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic ack_step();
        event_ack = 1'b1;
        step(1'b0);
        event_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn = 1'b0;
        event_ack = 1'b0;
        #3;
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", obs, 5'b00000);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        steps(1'b0, 3);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_glitch();
        steps(1'b1, 2);
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            total++;
            if (obs !== 5'b00000) begin
                bad++;
                $display("FAIL glitch_cycle%0d got=%b exp=%b", i, obs, 5'b00000);
            end
        end
    endtask

    task automatic test_single();
        steps(1'b1, 10);
        steps(1'b0, 31);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL single_early got=%b exp=%b", obs, 5'b00000);
        end
        step(1'b0);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL single_emit got=%b exp=%b", obs, 5'b10100);
        end
        step(1'b0);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL single_held got=%b exp=%b", obs, 5'b10100);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL single_ack got=%b exp=%b", obs, 5'b00000);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL stray_ack got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_min_boundary();
        steps(1'b1, 3);
        steps(1'b0, 40);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL min_minus1 got=%b exp=%b", obs, 5'b00000);
        end
        steps(1'b1, 4);
        steps(1'b0, 32);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL min_exact got=%b exp=%b", obs, 5'b10100);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL min_ack got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_double();
        steps(1'b1, 10);
        steps(1'b0, 8);
        steps(1'b1, 10);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL double_pre got=%b exp=%b", obs, 5'b00000);
        end
        step(1'b0);
        total++;
        if (obs !== 5'b11000) begin
            bad++;
            $display("FAIL double_emit got=%b exp=%b", obs, 5'b11000);
        end
        steps(1'b0, 40);
        total++;
        if (obs !== 5'b11000) begin
            bad++;
            $display("FAIL double_no_single got=%b exp=%b", obs, 5'b11000);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL double_ack got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_short_second();
        steps(1'b1, 10);
        steps(1'b0, 5);
        steps(1'b1, 3);
        step(1'b0);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL short_second got=%b exp=%b", obs, 5'b10100);
        end
        steps(1'b0, 40);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL short_second_held got=%b exp=%b", obs, 5'b10100);
        end
        ack_step();
    endtask

    task automatic test_gap_boundary();
        steps(1'b1, 10);
        steps(1'b0, 31);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL gap_31 got=%b exp=%b", obs, 5'b00000);
        end
        steps(1'b1, 10);
        step(1'b0);
        total++;
        if (obs !== 5'b11000) begin
            bad++;
            $display("FAIL gap_double got=%b exp=%b", obs, 5'b11000);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL gap_ack got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_long();
        steps(1'b1, 63);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL long_pre got=%b exp=%b", obs, 5'b00000);
        end
        step(1'b1);
        total++;
        if (obs !== 5'b11101) begin
            bad++;
            $display("FAIL long_emit got=%b exp=%b", obs, 5'b11101);
        end
        steps(1'b1, 36);
        total++;
        if (obs !== 5'b11101) begin
            bad++;
            $display("FAIL long_hold got=%b exp=%b", obs, 5'b11101);
        end
        step(1'b0);
        total++;
        if (obs !== 5'b11100) begin
            bad++;
            $display("FAIL long_release got=%b exp=%b", obs, 5'b11100);
        end
        steps(1'b0, 40);
        total++;
        if (obs !== 5'b11100) begin
            bad++;
            $display("FAIL long_no_event got=%b exp=%b", obs, 5'b11100);
        end
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL long_ack got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        steps(1'b1, 10);
        steps(1'b0, 32);
        steps(1'b1, 63);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL b2b_pending got=%b exp=%b", obs, 5'b10100);
        end
        event_ack = 1'b1;
        step(1'b1);
        event_ack = 1'b0;
        total++;
        if (obs !== 5'b11101) begin
            bad++;
            $display("FAIL b2b_ack_on_emit got=%b exp=%b", obs, 5'b11101);
        end
        step(1'b0);
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL b2b_clear got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    task automatic test_overrun();
        steps(1'b1, 10);
        steps(1'b0, 32);
        total++;
        if (obs !== 5'b10100) begin
            bad++;
            $display("FAIL ovr_first got=%b exp=%b", obs, 5'b10100);
        end
        steps(1'b1, 64);
        total++;
        if (obs !== 5'b10111) begin
            bad++;
            $display("FAIL ovr_drop got=%b exp=%b", obs, 5'b10111);
        end
        step(1'b0);
        total++;
        if (obs !== 5'b10110) begin
            bad++;
            $display("FAIL ovr_release got=%b exp=%b", obs, 5'b10110);
        end
    endtask

    task automatic test_async_reset();
        steps(1'b1, 10);
        steps(1'b0, 5);
        steps(1'b1, 3);
        total++;
        if (obs !== 5'b10110) begin
            bad++;
            $display("FAIL pre_reset got=%b exp=%b", obs, 5'b10110);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL async_reset got=%b exp=%b", obs, 5'b00000);
        end
        btn = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        steps(1'b1, 63);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL post_reset_pre got=%b exp=%b", obs, 5'b00000);
        end
        step(1'b1);
        total++;
        if (obs !== 5'b11101) begin
            bad++;
            $display("FAIL post_reset_long got=%b exp=%b", obs, 5'b11101);
        end
        step(1'b0);
        ack_step();
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("FAIL post_reset_clear got=%b exp=%b", obs, 5'b00000);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_min_boundary();
        test_double();
        test_short_second();
        test_gap_boundary();
        test_long();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/touch_gesture_decoder.md
Name: touch_gesture_decoder

Overview:
- Sits directly downstream of the capacitive touch sensor front-end and consumes its debounced `btn` level.
- Classifies each touch into one of three gestures: single tap, double tap or long press.
- Presents each gesture as a held event with a valid/ack handshake to the control logic.
- Also reports a live "long hold in progress" level.

Parameters:
- CNT_W, 16, width of the internal duration counter. All thresholds must be < 2^CNT_W.
- MIN_PRESS_CYCLES, 4, minimum consecutive high samples for a press to count. Shorter presses are discarded as glitches.
- LONG_PRESS_CYCLES, 64, consecutive high samples that declare a long press. Must be > MIN_PRESS_CYCLES and >= 2.
- DOUBLE_GAP_CYCLES, 32, consecutive low samples after a valid release that close the double-tap window.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn  in  1  debounced touch level from the sensor stage, synchronous to clk
- event_ack  in  1  consumer accepts the current event
- event_valid  out  1  an event is pending
- event_code  out  2  01 single tap, 10 double tap, 11 long press, 00 when no event pending
- overrun  out  1  sticky: an event was lost because the previous one was still pending
- hold  out  1  high while a long press is being held

Behaviour:
- Reset: `reset` low clears everything immediately, regardless of clk.
  - State = IDLE, counter = 0, btn_q = 0.
  - event_valid = 0, event_code = 00, overrun = 0, hold = 0.
  - Reset mid-gesture discards that gesture with no event.
- Edge detection:
  - btn_q is btn registered once.
  - rise = btn & ~btn_q; fall = ~btn & btn_q.
  - btn_q resets to 0, so btn already high at reset release counts as a rise on the first clock.
- "Consecutive samples" counts clock edges sampling the given btn level. The rising sample is high-sample 1; the falling sample is low-sample 1.
- Counter: cleared on every state entry, increments each cycle, saturates at all-ones.
- FSM (states IDLE, PRESS1, GAP, PRESS2, LONG):
  - IDLE: on rise -> PRESS1.
  - PRESS1, on fall:
    - if high-sample count < MIN_PRESS_CYCLES -> IDLE, no event;
    - otherwise -> GAP.
  - PRESS1, on the edge sampling the LONG_PRESS_CYCLES-th consecutive high -> LONG and emit long press (11).
  - GAP:
    - rise before the DOUBLE_GAP_CYCLES-th consecutive low sample -> PRESS2;
    - otherwise, on that edge -> IDLE and emit single tap (01).
  - PRESS2, on fall:
    - high-sample count >= MIN_PRESS_CYCLES -> IDLE and emit double tap (10);
    - count < MIN_PRESS_CYCLES -> IDLE and emit single tap (01).
  - PRESS2, reaching LONG_PRESS_CYCLES consecutive highs -> LONG and emit long press only; the first tap is dropped.
  - LONG: fall -> IDLE, no event.
- hold is registered and equals (state == LONG). It rises in the same cycle event_valid rises for a long press.
- Event register:
  - "Emit" loads event_code and sets event_valid at the same edge that makes the FSM transition.
  - Outputs are visible the following cycle.
  - event_valid stays high until a cycle with event_ack = 1. event_code returns to 00 on clear.
  - event_ack while event_valid = 0 is ignored.
- Simultaneous events:
  - Emit and event_ack in the same cycle: the new event is loaded, event_valid stays 1, overrun is unchanged.
  - Emit while event_valid = 1 and no ack: the new event is dropped, the old one is kept, overrun is set.
- overrun clears only on reset.

Test Plan:
- btn high 2 cycles, then low 100 cycles -> no event, state back to IDLE, event_valid stays 0.
- btn high 10, then low 40 -> event_valid high with code 01 starting the cycle after the 32nd low sample. Ack one cycle later -> event_valid 0, code 00.
- btn high 10, low 8, high 10, low -> event code 10 the cycle after the second fall. No single-tap event is generated.
- btn high 100 cycles -> code 11 and hold = 1 the cycle after the 64th high sample. hold drops the cycle after the fall. No event on release.
- Single tap left unacked, then a long press -> event_code stays 01, overrun = 1. Repeat with event_ack asserted on the emit cycle -> code 11 loaded, overrun unchanged.
- Assert reset low mid-PRESS2 (asynchronously, between edges) -> all outputs 0 immediately. After release with btn high -> a new press begins on the first clock.
